// File: rtl/sha_digest_uart_tx.sv
// sha_digest_uart_tx: latch digest on digest_valid rise, send NUM_BYTES 8N1 frames MSB byte first (in: clk rst digest digest_valid; out: tx busy done)
module sha_digest_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_BYTES = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*NUM_BYTES-1:0] digest,
  input  logic                   digest_valid,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);
  localparam int W = 8 * NUM_BYTES;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(NUM_BYTES);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0] bit_idx, bit_n;
  logic [IW-1:0] byte_idx, byte_n;
  logic [W-1:0] shift_reg, shift_n;
  logic [7:0] cur_n;
  logic dv_prev, tc, tx_n, done_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      shift_reg <= '0;
      dv_prev <= 1'b1;
      tx <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      baud_cnt <= baud_n;
      bit_idx <= bit_n;
      byte_idx <= byte_n;
      shift_reg <= shift_n;
      dv_prev <= digest_valid;
      tx <= tx_n;
      busy <= state_n != IDLE;
      done <= done_n;
    end
  end
  always_comb begin
    state_n = state;
    baud_n = baud_cnt;
    bit_n = bit_idx;
    byte_n = byte_idx;
    shift_n = shift_reg;
    done_n = 1'b0;
    tc = baud_cnt == BW'(CLKS_PER_BIT - 1);
    if (state == IDLE) begin
      if (digest_valid && !dv_prev) begin
        state_n = START;
        shift_n = digest;
        byte_n = '0;
        baud_n = '0;
        bit_n = '0;
      end
    end else begin
      baud_n = tc ? '0 : baud_cnt + 1'b1;
      if (tc)
        case (state)
          START: state_n = DATA;
          DATA: begin
            bit_n = bit_idx + 1'b1;
            state_n = bit_idx == 3'd7 ? STOP : DATA;
          end
          STOP:
            if (byte_idx == IW'(NUM_BYTES - 1)) begin
              state_n = IDLE;
              done_n = 1'b1;
            end else begin
              state_n = START;
              shift_n = shift_reg << 8;
              byte_n = byte_idx + 1'b1;
            end
          default: state_n = IDLE;
        endcase
    end
    cur_n = shift_n[W-1 -: 8];
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? cur_n[bit_n] : 1'b1;
  end
endmodule

// File: tb/tb_sha_digest_uart_tx.sv
// tb_sha_digest_uart_tx: self-checking bench for sha_digest_uart_tx
module tb_sha_digest_uart_tx;
  localparam int NB = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic [255:0] digest = '0;
  logic dv1 = 1'b0, dv2 = 1'b0;
  logic tx1, busy1, done1, tx2, busy2, done2;
  int checks = 0, failures = 0;
  logic cap_tx[0:4095], cap_busy[0:4095], cap_done[0:4095];
  typedef struct {
    logic [7:0] b;
    logic [9:0] frame;
  } vec_t;
  vec_t tbl[6];

  sha_digest_uart_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(NB)) u_dut (
    .clk(clk), .rst(rst), .digest(digest), .digest_valid(dv1),
    .tx(tx1), .busy(busy1), .done(done1)
  );
  sha_digest_uart_tx #(.CLKS_PER_BIT(2), .NUM_BYTES(NB)) u_dut2 (
    .clk(clk), .rst(rst), .digest(digest), .digest_valid(dv2),
    .tx(tx2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Ideal line level k cycles after the trigger: frames of start, 8 data LSB first, stop
  function automatic logic model_tx(input logic [255:0] d, input int c, input int k);
    int f, p;
    logic [7:0] b;
    if (k < 0 || k >= 10 * NB * c) return 1'b1;
    f = k / (10 * c);
    p = (k % (10 * c)) / c;
    b = d[255 - 8*f -: 8];
    return p == 0 ? 1'b0 : p == 9 ? 1'b1 : b[p-1];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_dv(input int sel, input logic v);
    if (sel == 1) dv1 = v;
    else dv2 = v;
  endtask

  // Starts a transmission and records n cycles; optional mid-run disturbance,
  // reset, and a re-trigger at index re with a new digest d2.
  task automatic run(input int sel, input logic [255:0] d, input int n, input int dis,
                     input int ab, input int re, input logic [255:0] d2);
    @(negedge clk);
    digest = d;
    set_dv(sel, 1'b0);
    @(negedge clk);
    set_dv(sel, 1'b1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cap_tx[k] = sel == 1 ? tx1 : tx2;
      cap_busy[k] = sel == 1 ? busy1 : busy2;
      cap_done[k] = sel == 1 ? done1 : done2;
      if (k == dis) begin
        digest = rand256();
        set_dv(sel, 1'b0);
      end
      if (k == dis + 1) set_dv(sel, 1'b1);
      if (k == ab) rst = 1'b1;
      if (k == ab + 1) rst = 1'b0;
      if (re >= 0 && k == 3) set_dv(sel, 1'b0);
      if (k == re) begin
        digest = d2;
        set_dv(sel, 1'b1);
      end
    end
  endtask

  task automatic verify(input string name, input logic [255:0] d, input int c, input int off);
    int bad, blen, dcnt;
    logic [7:0] dec;
    for (int f = 0; f < NB; f++) begin
      bad = 0;
      for (int j = 0; j < 10 * c; j++)
        if (cap_tx[off + f*10*c + j] !== model_tx(d, c, f*10*c + j)) bad++;
      for (int p = 1; p <= 8; p++) dec[p-1] = cap_tx[off + f*10*c + p*c + c/2];
      check($sformatf("%s byte%0d", name, f), 64'(dec), 64'(d[255 - 8*f -: 8]));
      check($sformatf("%s frame%0d bad_cycles", name, f), 64'(bad), 64'd0);
    end
    blen = 0;
    while (blen < 10 * NB * c + 5 && cap_busy[off + blen] === 1'b1) blen++;
    check($sformatf("%s busy_len", name), 64'(blen), 64'(10 * NB * c));
    dcnt = 0;
    for (int k = off; k <= off + 10 * NB * c; k++) if (cap_done[k] === 1'b1) dcnt++;
    check($sformatf("%s done_count", name), 64'(dcnt), 64'd1);
    check($sformatf("%s done_at_end", name), 64'(cap_done[off + 10 * NB * c]), 64'd1);
  endtask

  initial begin
    logic [255:0] d, e;
    logic [9:0] act;
    int bad;
    tbl[0] = '{8'hA5, 10'b0101001011};
    tbl[1] = '{8'h00, 10'b0000000001};
    tbl[2] = '{8'hFF, 10'b0111111111};
    tbl[3] = '{8'h01, 10'b0100000001};
    tbl[4] = '{8'h80, 10'b0000000011};
    tbl[5] = '{8'h3C, 10'b0001111001};
    repeat (3) @(negedge clk);
    check("reset tx1", 64'(tx1), 64'd1);
    check("reset busy1", 64'(busy1), 64'd0);
    check("reset done1", 64'(done1), 64'd0);
    check("reset tx2", 64'(tx2), 64'd1);
    rst = 1'b0;

    d = {4{64'h0123456789ABCDEF}};
    run(1, d, 1290, -1, -1, -1, '0);
    verify("pattern", d, 4, 0);

    d = rand256();
    for (int i = 0; i < 6; i++) d[255 - 8*i -: 8] = tbl[i].b;
    run(1, d, 1290, -1, -1, -1, '0);
    verify("table_run", d, 4, 0);
    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < 10; p++) act[9-p] = cap_tx[i*40 + p*4 + 2];
      check($sformatf("table frame %0d", i), 64'(act), 64'(tbl[i].frame));
    end

    repeat (2) begin
      d = rand256();
      run(1, d, 1290, -1, -1, -1, '0);
      verify("random", d, 4, 0);
    end

    dv1 = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy1 !== 1'b0 || tx1 !== 1'b1) bad++;
    end
    check("held_dv no_tx cycles", 64'(bad), 64'd0);
    d = rand256();
    run(1, d, 1290, -1, -1, -1, '0);
    verify("rearm", d, 4, 0);

    d = rand256();
    run(1, d, 1290, 405, -1, -1, '0);
    verify("ignore_edge", d, 4, 0);

    d = rand256();
    run(1, d, 260, -1, 213, -1, '0);
    check("abort tx", 64'(cap_tx[214]), 64'd1);
    check("abort busy", 64'(cap_busy[214]), 64'd0);
    check("abort done", 64'(cap_done[214]), 64'd0);
    bad = 0;
    for (int k = 0; k < 260; k++) if (cap_done[k] === 1'b1) bad++;
    for (int k = 214; k < 260; k++) if (cap_tx[k] !== 1'b1 || cap_busy[k] !== 1'b0) bad++;
    check("abort quiet cycles", 64'(bad), 64'd0);
    d = rand256();
    run(1, d, 1290, -1, -1, -1, '0);
    verify("after_abort", d, 4, 0);

    d = rand256();
    e = rand256();
    run(2, d, 1300, -1, -1, 640, e);
    verify("b2b_first", d, 2, 0);
    check("b2b tx low after done edge", 64'(cap_tx[641]), 64'd0);
    check("b2b busy after done edge", 64'(cap_busy[641]), 64'd1);
    verify("b2b_second", e, 2, 641);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
